// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one HI/LO multiply or divide operation.
// It starts the chosen unit, waits for that unit's completion with a timeout,
// writes HI/LO, and then reports op_done. A divide by zero or a timeout ends
// the operation with an exception instead, and HI/LO are left unchanged.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   op_valid     start request from main control (sampled only in IDLE)
//   op_sel       0 = mult, 1 = div (sampled with op_valid)
//   div_zero     divisor-is-zero flag (sampled with op_valid)
//   mult_done    multiplier completion pulse
//   div_done     divider completion pulse
//   start_multi  one-cycle multiplier start pulse
//   start_div    one-cycle divider start pulse
//   div_or_mult  HI/LO source select, 0 = multiplier, 1 = divider
//   high_write   HI load enable
//   low_write    LO load enable
//   busy         high in every state except IDLE
//   op_done      one-cycle completion pulse
//   exc          one-cycle exception pulse
//   exc_cause    0 = divide by zero, 1 = timeout
module muldiv_ctrl #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic op_valid,
    input  logic op_sel,
    input  logic div_zero,
    input  logic mult_done,
    input  logic div_done,
    output logic start_multi,
    output logic start_div,
    output logic div_or_mult,
    output logic high_write,
    output logic low_write,
    output logic busy,
    output logic op_done,
    output logic exc,
    output logic exc_cause
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_EXC
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel_lat, sel_nxt;
    logic             dom_nxt, cause_nxt;
    logic             sel_done;

    // Completion from the unit that was actually started; the other is ignored.
    assign sel_done = sel_lat ? div_done : mult_done;

    // Next-state and next-output decode.
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        sel_nxt    = sel_lat;
        dom_nxt    = div_or_mult;
        cause_nxt  = exc_cause;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_sel && div_zero) begin
                        next_state = S_EXC;
                        cause_nxt  = 1'b0;
                    end else begin
                        next_state = S_START;
                        sel_nxt    = op_sel;
                        dom_nxt    = op_sel;
                    end
                end
            end
            S_START: begin
                cnt_nxt    = '0;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (cnt != CNT_SAT) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                // A done arriving on the final allowed cycle still wins over timeout.
                if (sel_done) begin
                    next_state = S_WRITE;
                end else if (cnt == CNT_LAST) begin
                    next_state = S_EXC;
                    cause_nxt  = 1'b1;
                end
            end
            S_WRITE: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            S_EXC:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State, counter and registered outputs; outputs track the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sel_lat     <= 1'b0;
            start_multi <= 1'b0;
            start_div   <= 1'b0;
            div_or_mult <= 1'b0;
            high_write  <= 1'b0;
            low_write   <= 1'b0;
            busy        <= 1'b0;
            op_done     <= 1'b0;
            exc         <= 1'b0;
            exc_cause   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_nxt;
            sel_lat     <= sel_nxt;
            start_multi <= (next_state == S_START) && !sel_nxt;
            start_div   <= (next_state == S_START) && sel_nxt;
            div_or_mult <= dom_nxt;
            high_write  <= (next_state == S_WRITE);
            low_write   <= (next_state == S_WRITE);
            busy        <= (next_state != S_IDLE);
            op_done     <= (next_state == S_DONE);
            exc         <= (next_state == S_EXC);
            exc_cause   <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: each operation pushes its expected completion event
// (kind, cycle, cause, source select) and the monitor pops on op_done/exc.
module tb_muldiv_ctrl;

    localparam int unsigned MAXC = 40;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic op_valid = 1'b0;
    logic op_sel = 1'b0;
    logic div_zero = 1'b0;
    logic mult_done = 1'b0;
    logic div_done = 1'b0;
    logic start_multi, start_div, div_or_mult, high_write, low_write;
    logic busy, op_done, exc, exc_cause;

    typedef struct {
        bit is_exc;
        bit cause;
        bit dom;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   writes = 0;
    bit   last_dom = 1'b0;

    muldiv_ctrl #(.MAX_CYCLES(MAXC)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_sel      (op_sel),
        .div_zero    (div_zero),
        .mult_done   (mult_done),
        .div_done    (div_done),
        .start_multi (start_multi),
        .start_div   (start_div),
        .div_or_mult (div_or_mult),
        .high_write  (high_write),
        .low_write   (low_write),
        .busy        (busy),
        .op_done     (op_done),
        .exc         (exc),
        .exc_cause   (exc_cause)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (high_write || low_write) begin
            writes++;
            chk("hw_eq_lw", int'(high_write), int'(low_write));
            if (q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                chk("write_kind", int'(q[0].is_exc), 0);
                chk("write_cycle", cyc, q[0].cyc - 1);
            end
        end
        if (op_done || exc) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                e = q.pop_front();
                chk("evt_kind", int'(exc), int'(e.is_exc));
                chk("evt_single", int'(op_done && exc), 0);
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_dom", int'(div_or_mult), int'(e.dom));
                if (exc) chk("exc_cause", int'(exc_cause), int'(e.cause));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"}, int'({start_multi, start_div, div_or_mult, high_write,
                                 low_write, busy, op_done, exc, exc_cause}), 0);
    endtask

    // done_at: WAIT cycle with selected done (0 = never); busy_at: WAIT cycle with
    // a stray op_valid; foreign_at: WAIT cycle with the other unit's done.
    task automatic run_op(input bit sel, input bit dz, input int done_at,
                          input int busy_at, input int foreign_at);
        exp_t e;
        int   acc;
        int   last_w;
        @(negedge clock);
        op_valid = 1'b1; op_sel = sel; div_zero = dz;
        acc = cyc;
        if (sel && dz) begin
            e = '{is_exc: 1'b1, cause: 1'b0, dom: last_dom, cyc: acc + 1};
            q.push_back(e);
            @(negedge clock);
            op_valid = 1'b0; div_zero = 1'b0;
            chk("dz_no_start", int'(start_div || start_multi), 0);
            repeat (3) @(negedge clock);
            chk("dz_idle_busy", int'(busy), 0);
            chk("dz_cause_held", int'(exc_cause), 0);
            return;
        end
        last_dom = sel;
        if (done_at > 0) e = '{is_exc: 1'b0, cause: 1'b0, dom: sel, cyc: acc + 3 + done_at};
        else             e = '{is_exc: 1'b1, cause: 1'b1, dom: sel, cyc: acc + 2 + int'(MAXC)};
        q.push_back(e);
        @(negedge clock);
        op_valid = 1'b0;
        chk("start_multi", int'(start_multi), int'(!sel));
        chk("start_div", int'(start_div), int'(sel));
        chk("start_busy", int'(busy), 1);
        last_w = (done_at > 0) ? done_at : int'(MAXC);
        for (int w = 1; w <= last_w; w++) begin
            @(negedge clock);
            op_valid = 1'b0; mult_done = 1'b0; div_done = 1'b0;
            chk("wait_busy", int'(busy), 1);
            if (w == busy_at) begin
                op_valid = 1'b1; op_sel = 1'b1; div_zero = 1'b1;
            end
            if (w == foreign_at) begin
                if (sel) mult_done = 1'b1; else div_done = 1'b1;
            end
            if (w == done_at) begin
                if (sel) div_done = 1'b1; else mult_done = 1'b1;
            end
        end
        @(negedge clock);
        op_valid = 1'b0; mult_done = 1'b0; div_done = 1'b0; div_zero = 1'b0;
        repeat (4) @(negedge clock);
        chk("end_busy", int'(busy), 0);
        if (done_at == 0) chk("timeout_cause_held", int'(exc_cause), 1);
    endtask

    task automatic run_reset_mid();
        int wr0;
        @(negedge clock);
        op_valid = 1'b1; op_sel = 1'b1; div_zero = 1'b0;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        wr0 = writes;
        @(negedge clock);
        reset = 1'b1;
        chk_all_zero("reset_mid");
        last_dom = 1'b0;
        repeat (4) @(negedge clock);
        div_done = 1'b1;
        @(negedge clock);
        div_done = 1'b0;
        repeat (4) @(negedge clock);
        chk("reset_mid_no_write", writes, wr0);
        chk("reset_mid_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clock);
        run_op(1'b0, 1'b0, 33, 0, 0);          // mult, done on WAIT 33
        run_op(1'b0, 1'b0, 1, 0, 0);           // minimum latency
        run_op(1'b1, 1'b1, 0, 0, 0);           // divide by zero
        run_op(1'b1, 1'b0, 0, 0, 0);           // divide timeout
        run_op(1'b1, 1'b0, int'(MAXC), 0, 3);  // done on last cycle, stray mult_done
        run_op(1'b0, 1'b0, int'(MAXC) + 0, 0, 0); // mult done on last allowed cycle
        run_op(1'b0, 1'b0, 8, 5, 0);           // op_valid while busy ignored
        run_reset_mid();
        for (int i = 0; i < 4; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, MAXC)), 0, 0);
        end
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule
